// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - fetch-stage program counter / next-PC unit with optional return-address stack.
// Return-address stack is built only when PC_RAS_EN is defined.
module pc_gen #(
  parameter int              PC_W         = 32,
  parameter logic [PC_W-1:0] RESET_VECTOR = '0,
  parameter int              RAS_DEPTH    = 4
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            pc_en,
  input  logic            ihit,
  input  logic            dstall,
  input  logic [2:0]      PCSrc,
  input  logic            br_taken,
  input  logic [15:0]     imm16,
  input  logic [25:0]     immediate26,
  input  logic [PC_W-1:0] rdat1,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] pc_plus4,
  output logic            iren,
  output logic            misaligned,
  output logic            ras_empty,
  output logic            ras_full
);

  localparam logic [2:0] SRC_SEQ = 3'd0;
  localparam logic [2:0] SRC_BR  = 3'd1;
  localparam logic [2:0] SRC_J   = 3'd2;
  localparam logic [2:0] SRC_JAL = 3'd3;
  localparam logic [2:0] SRC_JR  = 3'd4;
  localparam logic [2:0] SRC_RET = 3'd5;

  if (PC_W < 28 || PC_W > 32 || RAS_DEPTH < 2 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0
      || RESET_VECTOR[1:0] != 2'b00) begin : g_bad_param
    $error("pc_gen: illegal parameter combination");
  end

  logic [PC_W-1:0] pc_q, pc_d;
  logic            mis_q, mis_d;
  logic            advance;
  logic [PC_W-1:0] br_off, j_tgt, reg_tgt;
  logic            push, pop;
  logic            ras_has;
  logic [PC_W-1:0] ras_top;

  assign advance  = pc_en & ihit & ~dstall;
  assign pc_plus4 = pc_q + PC_W'(4);
  assign br_off   = {{(PC_W-18){imm16[15]}}, imm16, 2'b00};
  assign reg_tgt  = {rdat1[PC_W-1:2], 2'b00};

  // PC_W=28 leaves no upper bits to carry over from pc_plus4.
  if (PC_W > 28) begin : g_j_upper
    assign j_tgt = {pc_plus4[PC_W-1:28], immediate26, 2'b00};
  end else begin : g_j_plain
    assign j_tgt = {immediate26, 2'b00};
  end

  always_comb begin
    pc_d  = pc_q;
    mis_d = 1'b0;
    push  = 1'b0;
    pop   = 1'b0;
    if (advance) begin
      case (PCSrc)
        SRC_BR:  pc_d = br_taken ? (pc_plus4 + br_off) : pc_plus4;
        SRC_J:   pc_d = j_tgt;
        SRC_JAL: begin
          pc_d = j_tgt;
          push = 1'b1;
        end
        SRC_JR: begin
          pc_d  = reg_tgt;
          mis_d = |rdat1[1:0];
        end
        SRC_RET: begin
          if (ras_has) begin
            pc_d = ras_top;
            pop  = 1'b1;
          end else begin
            pc_d  = reg_tgt;
            mis_d = |rdat1[1:0];
          end
        end
        default: pc_d = pc_plus4;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pc_q  <= RESET_VECTOR;
      mis_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      mis_q <= mis_d;
    end
  end

`ifdef PC_RAS_EN
  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam logic [PTR_W:0] CNT_MAX = (PTR_W+1)'(RAS_DEPTH);

  logic [PC_W-1:0]  ras_q [RAS_DEPTH];
  logic [PTR_W-1:0] top_q, top_d;
  logic [PTR_W:0]   cnt_q, cnt_d;

  assign ras_has = (cnt_q != '0);
  assign ras_top = ras_q[top_q];

  // Pushing into a full stack lands on the oldest slot, so the wrap overwrites it.
  always_comb begin
    top_d = top_q;
    cnt_d = cnt_q;
    if (push) begin
      top_d = top_q + 1'b1;
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    end else if (pop) begin
      top_d = top_q - 1'b1;
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      top_q <= '0;
      cnt_q <= '0;
    end else begin
      top_q <= top_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) ras_q[top_d] <= pc_plus4;
  end

  assign ras_empty = (cnt_q == '0);
  assign ras_full  = (cnt_q == CNT_MAX);
`else
  assign ras_has   = 1'b0;
  assign ras_top   = '0;
  assign ras_empty = 1'b1;
  assign ras_full  = 1'b0;
`endif

  assign pc         = pc_q;
  assign misaligned = mis_q;
  assign iren       = ~RST;

endmodule

// File: tb/tb_pc_gen.sv
// tb/tb_pc_gen.sv - directed self-checking bench for pc_gen.
module tb_pc_gen;

  logic        CLK = 1'b0;
  logic        RST;
  logic        pc_en, ihit, dstall, br_taken;
  logic [2:0]  PCSrc;
  logic [15:0] imm16;
  logic [25:0] immediate26;
  logic [31:0] rdat1;
  logic [31:0] pc, pc_plus4;
  logic        iren, misaligned, ras_empty, ras_full;

  int passed = 0;
  int total  = 0;

  pc_gen #(.PC_W(32), .RESET_VECTOR(32'h0), .RAS_DEPTH(4)) dut (
    .CLK(CLK), .RST(RST), .pc_en(pc_en), .ihit(ihit), .dstall(dstall),
    .PCSrc(PCSrc), .br_taken(br_taken), .imm16(imm16), .immediate26(immediate26),
    .rdat1(rdat1), .pc(pc), .pc_plus4(pc_plus4), .iren(iren),
    .misaligned(misaligned), .ras_empty(ras_empty), .ras_full(ras_full)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic go(input logic [2:0] src, input logic [31:0] r);
    PCSrc = src;
    rdat1 = r;
    step();
  endtask

  initial begin
    RST = 1'b1; pc_en = 1'b0; ihit = 1'b0; dstall = 1'b0; br_taken = 1'b0;
    PCSrc = 3'd0; imm16 = 16'h0; immediate26 = 26'h0; rdat1 = 32'h0;
    #2;
    check("rst_pc", pc, 32'h0);
    check("rst_mis", {31'b0, misaligned}, 32'h0);
    check("rst_ras_empty", {31'b0, ras_empty}, 32'h1);
    check("rst_ras_full", {31'b0, ras_full}, 32'h0);
    check("rst_iren", {31'b0, iren}, 32'h0);
    step();
    RST = 1'b0; pc_en = 1'b1; ihit = 1'b1;
    #1;
    check("iren", {31'b0, iren}, 32'h1);
    check("seq0", pc, 32'h0);
    for (int i = 1; i < 5; i++) begin
      go(3'd0, 32'h0);
      check("seq", pc, 32'(4 * i));
    end
    #2 RST = 1'b1;
    #1 check("async_rst", pc, 32'h0);
    RST = 1'b0;
    step();
    check("post_rst", pc, 32'h4);

    go(3'd4, 32'h100);
    check("jr100", pc, 32'h100);
    br_taken = 1'b1; imm16 = 16'hFFFE;
    go(3'd1, 32'h0);
    check("br_taken", pc, 32'hFC);
    go(3'd4, 32'h100);
    br_taken = 1'b0;
    go(3'd1, 32'h0);
    check("br_not", pc, 32'h104);

    ihit = 1'b0;
    for (int i = 0; i < 3; i++) begin
      go(3'd0, 32'h0);
      check("ihit_stall", pc, 32'h104);
    end
    ihit = 1'b1; dstall = 1'b1;
    go(3'd0, 32'h0);
    check("dstall", pc, 32'h104);
    dstall = 1'b0;
    go(3'd0, 32'h0);
    check("release", pc, 32'h108);
    check("plus4", pc_plus4, 32'h10C);
    pc_en = 1'b0;
    go(3'd0, 32'h0);
    check("pc_en_hold", pc, 32'h108);
    pc_en = 1'b1;

    go(3'd4, 32'h0040_0000);
    immediate26 = 26'h000ABCD;
    go(3'd3, 32'h0);
    check("jal", pc, 32'h0002_AF34);
`ifdef PC_RAS_EN
    check("jal_ras_empty", {31'b0, ras_empty}, 32'h0);
    go(3'd5, 32'h0);
    check("ret", pc, 32'h0040_0004);
`else
    check("jal_ras_empty", {31'b0, ras_empty}, 32'h1);
    go(3'd5, 32'h0);
    check("ret", pc, 32'h0);
`endif
    check("ret_ras_empty", {31'b0, ras_empty}, 32'h1);

`ifdef PC_RAS_EN
    for (int i = 1; i <= 5; i++) begin
      go(3'd4, 32'(i * 32'h1000));
      go(3'd3, 32'h0);
    end
    check("ras_full", {31'b0, ras_full}, 32'h1);
    for (int i = 5; i >= 2; i--) begin
      go(3'd5, 32'h0);
      check("ras_pop", pc, 32'(i * 32'h1000 + 4));
    end
    go(3'd5, 32'h200);
    check("ras_empty_pop", pc, 32'h200);
    check("ras_empty_after", {31'b0, ras_empty}, 32'h1);
`endif

    go(3'd4, 32'h203);
    check("jr_mis_pc", pc, 32'h200);
    check("jr_mis", {31'b0, misaligned}, 32'h1);
    go(3'd0, 32'h0);
    check("mis_clear", {31'b0, misaligned}, 32'h0);
    check("mis_seq", pc, 32'h204);
    go(3'd5, 32'h300);
    check("ret_reg", pc, 32'h300);
    check("ret_reg_empty", {31'b0, ras_empty}, 32'h1);
    check("ret_reg_mis", {31'b0, misaligned}, 32'h0);
    go(3'd5, 32'h301);
    check("ret_mis_pc", pc, 32'h300);
    check("ret_mis", {31'b0, misaligned}, 32'h1);
    pc_en = 1'b0;
    go(3'd4, 32'h203);
    check("stall_mis_clear", {31'b0, misaligned}, 32'h0);
    check("stall_jr_hold", pc, 32'h300);
    pc_en = 1'b1;

    go(3'd4, 32'hFFFF_FFFC);
    check("wrap_plus4", pc_plus4, 32'h0);
    go(3'd0, 32'h0);
    check("wrap_pc", pc, 32'h0);
    go(3'd7, 32'h0);
    check("src7_seq", pc, 32'h4);

    go(3'd4, 32'hF000_0000);
    immediate26 = 26'h3FF_FFFF;
    go(3'd2, 32'h0);
    check("j_upper", pc, 32'hFFFF_FFFC);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1);
  end

endmodule
